cache_sim_core: RTL
===================

Name: cache_sim_core

Overview:
- Parametrised, handshaked successor to the trace-driven cache model.
- Accepts one read, write or invalidate request at a time and updates tag, valid, dirty and replacement state.
- Returns a per-request hit/evict/writeback response and keeps saturating statistics counters.
- Sits between the trace-reader testbench front end and the statistics report; supports selectable True-LRU or tree pseudo-LRU replacement.

Parameters:
- NUM_SETS, 32, number of sets; power of 2, ≥2.
- NUM_WAYS, 8, associativity; range 1..8.
- LINE_SIZE, 64, line size in bytes; power of 2, range 32..128.
- REPL_POLICY, 0, 0 = True LRU (per-way age), 1 = tree pseudo-LRU. Policy 1 requires NUM_WAYS to be a power of 2; otherwise $error at elaboration.
- ADDR_W, 32, address width.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  core idle; request accepted when req_valid && req_ready.
- req_type  in  2  0 = read, 1 = write, 2 = invalidate, 3 = reserved.
- req_addr  in  ADDR_W  byte address, split as {tag, index, byte_select}.
- clear_stats  in  1  synchronously zeroes all stat_* counters.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_hit  out  1  tag matched a valid way.
- resp_evict  out  1  a valid line was replaced.
- resp_writeback  out  1  the evicted line was dirty.
- resp_way  out  3  way hit, filled or invalidated; 0 if none.
- stat_accesses, stat_reads, stat_writes, stat_invalidates, stat_hits, stat_misses, stat_evictions, stat_writebacks  out  CNT_W each  statistics counters.

Behaviour:
- Reset: FSM to IDLE; all valid, dirty and PLRU bits cleared; age[set][w] = w (way 0 MRU); every stat_* = 0; resp_* = 0; req_ready = 1.
- Reset mid-operation drops the in-flight request. No resp_valid is produced for it.
- FSM states: IDLE → LOOKUP → UPDATE → IDLE.
  - IDLE: req_ready = 1; on accept, latch type, tag and index.
  - LOOKUP: compare all ways of the latched set; select the hit way or the victim.
  - UPDATE: write arrays and counters.
- Latency: request accepted on edge N; resp_valid is high in cycle N+3, coincident with IDLE. Sustained throughput is 1 request per 3 cycles.
- Victim selection:
  - Lowest-index invalid way if any; no eviction is counted.
  - Else True LRU: the way with age NUM_WAYS−1.
  - Else PLRU: walk the tree bits from the root.
- Touch on hit or fill:
  - LRU: ways with age < touched age increment; touched way's age = 0.
  - PLRU: tree bits on the path are set to point away from the touched way.
- Read:
  - Hit: hits+1.
  - Miss: misses+1; fill with dirty = 0.
  - Both cases: reads+1, accesses+1.
- Write:
  - Hit: set dirty = 1.
  - Miss: fill with dirty = 1.
  - Counts as for read, with writes+1 instead of reads+1.
- Eviction (all ways valid on a miss): evictions+1; writebacks+1 if the victim is dirty.
- Invalidate:
  - invalidates+1 only; not counted as an access.
  - On a valid tag match: clear valid and dirty; no writeback is counted. LRU: the way's age becomes NUM_WAYS−1 and older ways decrement. PLRU: bits unchanged.
  - On no match: no state change; resp_hit = 0.
- req_type 3: accepted and completes normally, but with no array or counter change; all resp flags are 0.
- Counters saturate at all-ones and never wrap.
- clear_stats: clears all counters; when asserted in the same cycle as an UPDATE increment, clear wins.
- NUM_WAYS = 1: direct-mapped; REPL_POLICY is ignored; resp_way = 0.

Optional Feature:
- Macro: CACHE_TRACE_EN.
- Defined: on each resp_valid, $display one line containing $time, type, set, tag, hit/miss, way, evict, writeback.
- Undefined: no display output; functional behaviour and timing are identical.

Test Plan:
Default parameters: index = addr[10:6]; set-0 stride = 0x800.
- T1: Reset, read 0x0000_0040 → miss (accesses = 1, misses = 1); read it again → resp_hit = 1, hits = 1; resp_valid exactly 3 cycles after each accept.
- T2: Write 0x0000, 0x0800 … 0x3800, then read 0x4000 → resp_evict = 1, resp_writeback = 1, resp_way = 0; final counters writes = 8, evictions = 1, writebacks = 1.
- T3: LRU (policy 0). Read-fill set 0 with 0x0000 … 0x3800, re-read 0x0000, then read 0x4000 → victim way 1, writeback = 0. Then read 0x0800 → miss.
- T4: PLRU (policy 1). Read-fill 0x0000 … 0x3800, then read 0x4000 → victim way 0.
- T5: Write 0x0800, invalidate 0x0800 → invalidates = 1, writebacks unchanged. Then write 0x4800 → fills way 1 with no eviction. Invalidate 0x9000 (absent) → resp_hit = 0, state unchanged.
- T6: Assert rst during LOOKUP → no resp_valid, counters = 0. Pulse clear_stats in the same cycle as UPDATE → counters read 0. Drive hits to all-ones with CNT_W = 4 → hits stays at 15.

Source files
------------

// File: rtl/cache_sim_core.sv
// Handshaked set-associative cache model: IDLE -> LOOKUP -> UPDATE per request, with
// True-LRU or tree pseudo-LRU replacement and saturating statistics. Trace output: CACHE_TRACE_EN.
module cache_sim_core #(
    parameter int NUM_SETS    = 32,
    parameter int NUM_WAYS    = 8,
    parameter int LINE_SIZE   = 64,
    parameter int REPL_POLICY = 0,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              clear_stats,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_evict,
    output logic              resp_writeback,
    output logic [2:0]        resp_way,
    output logic [CNT_W-1:0]  stat_accesses,
    output logic [CNT_W-1:0]  stat_reads,
    output logic [CNT_W-1:0]  stat_writes,
    output logic [CNT_W-1:0]  stat_invalidates,
    output logic [CNT_W-1:0]  stat_hits,
    output logic [CNT_W-1:0]  stat_misses,
    output logic [CNT_W-1:0]  stat_evictions,
    output logic [CNT_W-1:0]  stat_writebacks,
    output logic [1:0]        fsm_state
);

    localparam int OFF_W = $clog2(LINE_SIZE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int LVL   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
    localparam bit USE_PLRU = (REPL_POLICY == 1) && (NUM_WAYS > 1);
    localparam logic [2:0] OLDEST = 3'(NUM_WAYS - 1);

    localparam logic [1:0] OP_RD  = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_INV = 2'd2;

    if (REPL_POLICY == 1 && (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_policy_check
        $error("cache_sim_core: tree pseudo-LRU needs a power-of-2 NUM_WAYS");
    end

    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid pulses for one cycle on return to IDLE.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_UPDATE = 2'd2} state_t;
    state_t state_q, state_d;

    logic [1:0]       op_type;
    logic [TAG_W-1:0] op_tag;
    logic [IDX_W-1:0] op_idx;
    logic             lk_hit, lk_evict, lk_wb;
    logic [2:0]       lk_way;

    logic [TAG_W-1:0]    tag_mem   [NUM_SETS][NUM_WAYS];
    logic [2:0]          age_mem   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];
    logic [6:0]          plru_mem  [NUM_SETS];

    logic       l_hit, l_inv_found;
    logic [2:0] l_hit_way, l_inv_way, l_lru_way, l_plru_way, l_victim;

    logic unused_offset;
    assign unused_offset = ^req_addr[OFF_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Tree bit 0 steers left, 1 steers right; the victim follows the bits from the root.
    function automatic logic [2:0] plru_victim(input logic [6:0] t);
        logic [3:0] node;
        node = 4'd1;
        for (int l = 0; l < LVL; l++) node = {node[2:0], t[3'(node - 4'd1)]};
        return 3'(node - 4'(NUM_WAYS));
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] way);
        logic [6:0] r;
        logic [3:0] node;
        logic       b;
        r    = t;
        node = 4'd1;
        for (int l = LVL - 1; l >= 0; l--) begin
            b = way[l];
            r[3'(node - 4'd1)] = ~b;
            node = {node[2:0], b};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign fsm_state = state_q;

    always_comb begin
        l_hit       = 1'b0;
        l_hit_way   = 3'd0;
        l_inv_found = 1'b0;
        l_inv_way   = 3'd0;
        l_lru_way   = 3'd0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_mem[op_idx][w] && tag_mem[op_idx][w] == op_tag && !l_hit) begin
                l_hit     = 1'b1;
                l_hit_way = 3'(w);
            end
            if (!valid_mem[op_idx][w] && !l_inv_found) begin
                l_inv_found = 1'b1;
                l_inv_way   = 3'(w);
            end
            if (age_mem[op_idx][w] == OLDEST) l_lru_way = 3'(w);
        end
        l_plru_way = plru_victim(plru_mem[op_idx]);
        if (l_inv_found)   l_victim = l_inv_way;
        else if (USE_PLRU) l_victim = l_plru_way;
        else               l_victim = l_lru_way;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_type        <= 2'd0;
            op_tag         <= '0;
            op_idx         <= '0;
            lk_hit         <= 1'b0;
            lk_evict       <= 1'b0;
            lk_wb          <= 1'b0;
            lk_way         <= 3'd0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_evict     <= 1'b0;
            resp_writeback <= 1'b0;
            resp_way       <= 3'd0;
        end else begin
            resp_valid <= 1'b0;
            if (state_q == S_IDLE && req_valid) begin
                op_type <= req_type;
                op_tag  <= req_addr[ADDR_W-1 -: TAG_W];
                op_idx  <= req_addr[OFF_W +: IDX_W];
            end
            if (state_q == S_LOOKUP) begin
                lk_hit   <= 1'b0;
                lk_evict <= 1'b0;
                lk_wb    <= 1'b0;
                lk_way   <= 3'd0;
                if (op_type == OP_RD || op_type == OP_WR) begin
                    lk_hit   <= l_hit;
                    lk_way   <= l_hit ? l_hit_way : l_victim;
                    lk_evict <= !l_hit && !l_inv_found;
                    lk_wb    <= !l_hit && !l_inv_found && dirty_mem[op_idx][l_victim];
                end else if (op_type == OP_INV) begin
                    lk_hit <= l_hit;
                    lk_way <= l_hit ? l_hit_way : 3'd0;
                end
            end
            if (state_q == S_UPDATE) begin
                resp_valid     <= 1'b1;
                resp_hit       <= lk_hit;
                resp_evict     <= lk_evict;
                resp_writeback <= lk_wb;
                resp_way       <= lk_way;
            end
        end
    end

    // Array update; ages stay a permutation of 0..NUM_WAYS-1 within every set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                plru_mem[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_mem[s][w] <= 3'(w);
            end
        end else if (state_q == S_UPDATE) begin
            if (op_type == OP_RD || op_type == OP_WR) begin
                if (!lk_hit) begin
                    tag_mem[op_idx][lk_way]   <= op_tag;
                    valid_mem[op_idx][lk_way] <= 1'b1;
                end
                if (op_type == OP_WR) dirty_mem[op_idx][lk_way] <= 1'b1;
                else if (!lk_hit)     dirty_mem[op_idx][lk_way] <= 1'b0;
                if (USE_PLRU) begin
                    plru_mem[op_idx] <= plru_touch(plru_mem[op_idx], lk_way);
                end else begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (3'(w) == lk_way)
                            age_mem[op_idx][w] <= 3'd0;
                        else if (age_mem[op_idx][w] < age_mem[op_idx][lk_way])
                            age_mem[op_idx][w] <= age_mem[op_idx][w] + 3'd1;
                    end
                end
            end else if (op_type == OP_INV && lk_hit) begin
                valid_mem[op_idx][lk_way] <= 1'b0;
                dirty_mem[op_idx][lk_way] <= 1'b0;
                if (!USE_PLRU) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (3'(w) == lk_way)
                            age_mem[op_idx][w] <= OLDEST;
                        else if (age_mem[op_idx][w] > age_mem[op_idx][lk_way])
                            age_mem[op_idx][w] <= age_mem[op_idx][w] - 3'd1;
                    end
                end
            end
        end
    end

    // clear_stats outranks any increment landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            stat_accesses    <= '0;
            stat_reads       <= '0;
            stat_writes      <= '0;
            stat_invalidates <= '0;
            stat_hits        <= '0;
            stat_misses      <= '0;
            stat_evictions   <= '0;
            stat_writebacks  <= '0;
        end else if (state_q == S_UPDATE) begin
            if (op_type == OP_RD || op_type == OP_WR) begin
                stat_accesses <= sat_inc(stat_accesses);
                if (op_type == OP_RD) stat_reads  <= sat_inc(stat_reads);
                else                  stat_writes <= sat_inc(stat_writes);
                if (lk_hit) stat_hits   <= sat_inc(stat_hits);
                else        stat_misses <= sat_inc(stat_misses);
                if (lk_evict) stat_evictions  <= sat_inc(stat_evictions);
                if (lk_wb)    stat_writebacks <= sat_inc(stat_writebacks);
            end else if (op_type == OP_INV) begin
                stat_invalidates <= sat_inc(stat_invalidates);
            end
        end
    end

`ifdef CACHE_TRACE_EN
    always @(posedge clk) begin
        if (resp_valid)
            $display("%0t type=%0d set=%0d tag=%0h %s way=%0d evict=%0d wb=%0d", $time, op_type,
                     op_idx, op_tag, resp_hit ? "hit" : "miss", resp_way, resp_evict, resp_writeback);
    end
`else
    // Trace output compiled out; behaviour and timing are unchanged.
`endif

endmodule
